// File: rtl/env_amp_pdm.sv
// Envelope amplitude stage: 3-stage pipelined PCM x envelope scaler feeding a
// free-running first-order sigma-delta modulator that drives a 1-bit PDM pin.
module env_amp_pdm #(
  parameter int PCM_W = 16,
  parameter int ENV_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [PCM_W-1:0] pcm_in,
  input  logic                    pcm_valid,
  input  logic        [ENV_W-1:0] env,
  output logic signed [PCM_W-1:0] mod_pcm,
  output logic                    mod_valid,
  output logic                    pdm_out
);

  localparam int PROD_W = PCM_W + ENV_W + 1;

  logic signed [PCM_W-1:0]  pcm1_q;
  logic        [ENV_W-1:0]  env1_q;
  logic                     v1_q;
  logic signed [PROD_W-1:0] prod2_q, prod2_d;
  logic                     v2_q;
  logic signed [PCM_W-1:0]  mod_pcm_q;
  logic                     mod_valid_q;
  logic        [PCM_W-1:0]  acc_q;
  logic                     pdm_q;
  logic        [PCM_W-1:0]  u_d;
  logic        [PCM_W:0]    sum_d;

  // The zero-extended envelope makes the multiply a signed x non-negative product.
  always_comb begin
    prod2_d = pcm1_q * $signed({1'b0, env1_q});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcm1_q      <= '0;
      env1_q      <= '0;
      v1_q        <= 1'b0;
      prod2_q     <= '0;
      v2_q        <= 1'b0;
      mod_pcm_q   <= '0;
      mod_valid_q <= 1'b0;
    end else begin
      v1_q        <= pcm_valid;
      if (pcm_valid) begin
        pcm1_q <= pcm_in;
        env1_q <= env;
      end
      v2_q        <= v1_q;
      prod2_q     <= prod2_d;
      mod_valid_q <= v2_q;
      if (v2_q) begin
        mod_pcm_q <= prod2_q[PCM_W+ENV_W-1:ENV_W];
      end
    end
  end

  // Offset-binary input turns the signed sample into a 0..1 ones density.
  always_comb begin
    u_d   = $unsigned(mod_pcm_q) ^ {1'b1, {(PCM_W-1){1'b0}}};
    sum_d = {1'b0, acc_q} + {1'b0, u_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= sum_d[PCM_W-1:0];
      pdm_q <= sum_d[PCM_W];
    end
  end

  assign mod_pcm   = mod_pcm_q;
  assign mod_valid = mod_valid_q;
  assign pdm_out   = pdm_q;

endmodule

// File: tb/tb_env_amp_pdm.sv
// Directed self-checking bench for env_amp_pdm: reset, latency, corner products,
// back-to-back ramp, PDM ones density and reset with samples in flight.
module tb_env_amp_pdm;

  logic               clk;
  logic               reset_n;
  logic signed [15:0] pcm_in;
  logic               pcm_valid;
  logic        [15:0] env;
  logic signed [15:0] mod_pcm;
  logic               mod_valid;
  logic               pdm_out;

  int checks;
  int errors;

  env_amp_pdm #(.PCM_W(16), .ENV_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .env       (env),
    .mod_pcm   (mod_pcm),
    .mod_valid (mod_valid),
    .pdm_out   (pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one sample for one capture edge and waits (bounded) for its result.
  task automatic run_sample(input logic [15:0] p, input logic [15:0] e,
                            output logic [15:0] res, output int lat);
    @(posedge clk); #1;
    pcm_in = p; env = e; pcm_valid = 1'b1;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    lat = 1;
    while (!mod_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    res = mod_pcm;
    if (!mod_valid) lat = -1;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (pdm_out) ones++;
    end
  endtask

  task automatic test_reset();
    int ones;
    logic prev;
    logic alt_ok;
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pcm_valid = i[0];
      pcm_in = 16'sh1234; env = 16'hFFFF;
    end
    pcm_valid = 1'b0;
    checks++;
    if (pdm_out !== 1'b0 || mod_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: pdm_out=%b mod_valid=%b, required 0/0", pdm_out, mod_valid);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if (mod_valid !== 1'b0 || mod_pcm !== 16'sh0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: mod_valid=%b mod_pcm=%h, required 0/0000", mod_valid, mod_pcm);
    end
    ones = 0; alt_ok = 1'b1; prev = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (pdm_out === prev) alt_ok = 1'b0;
      if (i == 0 && pdm_out !== 1'b0) alt_ok = 1'b0;
      if (pdm_out === 1'b1) ones++;
      prev = pdm_out;
      if (mod_valid !== 1'b0) alt_ok = 1'b0;
    end
    checks++;
    if (ones != 32) begin
      errors++;
      $display("[TB] FAIL reset_pdm_ones: got %0d ones in 64 clks, required 32", ones);
    end
    checks++;
    if (!alt_ok) begin
      errors++;
      $display("[TB] FAIL reset_pdm_alternate: pattern not 0,1,0,1 (or stray mod_valid), required strict alternation");
    end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    pcm_in = 16'sh4000; env = 16'h8000; pcm_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      pcm_valid = 1'b0;
      env = 16'h0000;
      checks++;
      if (mod_valid !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL latency_valid_T+%0d: mod_valid=%b, required %b", k, mod_valid, (k == 3));
      end
      if (k >= 3) begin
        checks++;
        if (mod_pcm !== 16'sh2000) begin
          errors++;
          $display("[TB] FAIL latency_value_T+%0d: mod_pcm=%h, required 2000", k, mod_pcm);
        end
      end
    end
  endtask

  task automatic test_corners();
    logic [15:0] pv [5] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h5A5A, 16'h8000};
    logic [15:0] ev [5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] xv [5] = '{16'h8000, 16'h7FFE, 16'hFFFF, 16'h0000, 16'h0000};
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_sample(pv[i], ev[i], res, lat);
      checks++;
      if (lat != 3 || res !== xv[i]) begin
        errors++;
        $display("[TB] FAIL corner_%0d: pcm=%h env=%h -> mod_pcm=%h latency=%0d, required %h latency 3",
                 i, pv[i], ev[i], res, lat, xv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last_cycle;
    int gap_err;
    int val_err;
    logic [15:0] expv;
    pulses = 0; last_cycle = -1; gap_err = 0; val_err = 0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          @(posedge clk); #1;
          pcm_valid = 1'b1; pcm_in = 16'(n); env = 16'hFFFF;
        end
        @(posedge clk); #1;
        pcm_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 112; c++) begin
          @(posedge clk); #1;
          if (mod_valid === 1'b1) begin
            expv = (pulses == 0) ? 16'h0000 : 16'(pulses - 1);
            if (mod_pcm !== expv) begin
              if (val_err == 0)
                $display("[TB] FAIL ramp_value_%0d: mod_pcm=%h, required %h", pulses, mod_pcm, expv);
              val_err++;
            end
            if (last_cycle >= 0 && c != last_cycle + 1) gap_err++;
            last_cycle = c;
            pulses++;
          end
        end
      end
    join
    checks++;
    if (pulses != 100) begin
      errors++;
      $display("[TB] FAIL ramp_count: %0d mod_valid pulses, required 100", pulses);
    end
    checks++;
    if (gap_err != 0) begin
      errors++;
      $display("[TB] FAIL ramp_consecutive: %0d gaps between pulses, required 0", gap_err);
    end
    checks++;
    if (val_err != 0) begin
      errors++;
      $display("[TB] FAIL ramp_values: %0d wrong samples, required 0", val_err);
    end
  endtask

  task automatic test_pdm_density();
    logic [15:0] pv [3] = '{16'h7FFF, 16'h8000, 16'h1234};
    logic [15:0] ev [3] = '{16'h8002, 16'hFFFF, 16'h0000};
    logic [15:0] xv [3] = '{16'h4000, 16'h8000, 16'h0000};
    int          xo [3] = '{768, 0, 512};
    logic [15:0] res;
    int lat;
    int ones;
    for (int i = 0; i < 3; i++) begin
      run_sample(pv[i], ev[i], res, lat);
      checks++;
      if (lat != 3 || res !== xv[i]) begin
        errors++;
        $display("[TB] FAIL pdm_setup_%0d: mod_pcm=%h latency=%0d, required %h latency 3", i, res, lat, xv[i]);
      end
      repeat (2) @(posedge clk);
      #1;
      count_ones(1024, ones);
      checks++;
      if (ones != xo[i]) begin
        errors++;
        $display("[TB] FAIL pdm_density_%h: %0d ones in 1024 clks, required %0d", xv[i], ones, xo[i]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [15:0] res;
    int lat;
    int stray;
    @(posedge clk); #1;
    pcm_valid = 1'b1; pcm_in = 16'sh1000; env = 16'hFFFF;
    @(posedge clk); #1;
    pcm_in = 16'sh2000;
    @(posedge clk); #1;
    pcm_in = 16'sh3000;
    reset_n = 1'b0;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    reset_n = 1'b1;
    checks++;
    if (mod_valid !== 1'b0 || mod_pcm !== 16'sh0000) begin
      errors++;
      $display("[TB] FAIL flight_reset_clear: mod_valid=%b mod_pcm=%h, required 0/0000", mod_valid, mod_pcm);
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mod_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL flight_discard: %0d mod_valid pulses after reset, required 0", stray);
    end
    run_sample(16'hC000, 16'h8000, res, lat);
    checks++;
    if (lat != 3 || res !== 16'hE000) begin
      errors++;
      $display("[TB] FAIL flight_recover: mod_pcm=%h latency=%0d, required e000 latency 3", res, lat);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; pcm_valid = 1'b0; pcm_in = '0; env = '0;
    test_reset();
    test_latency();
    test_corners();
    test_back_to_back();
    test_pdm_density();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
